score_tracker: RTL

SCORE_TRACKER -- requirements
Module: score_tracker

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/bcd_counter2.sv | 46 ++++
 rtl/score_tracker.sv | 102 ++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the line-clear score tracker.
// Holds the game state encoding, the points table and the score ceiling.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_ADD,
    ST_WIN,
    ST_LOSE
  } state_e;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  localparam logic [3:0] PTS_1 = 4'd1;
  localparam logic [3:0] PTS_2 = 4'd3;
  localparam logic [3:0] PTS_3 = 4'd5;
  localparam logic [3:0] PTS_4 = 4'd8;

  // A zero result means the report carries no points.
  function automatic logic [3:0] points_for(input logic [2:0] lines);
    case (lines)
      3'd1:    return PTS_1;
      3'd2:    return PTS_2;
      3'd3:    return PTS_3;
      3'd4:    return PTS_4;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit score counter kept in binary and BCD side by side.
// Stops at SCORE_MAX, so the digits never need a divider.
module bcd_counter2
  import tetris_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Clear,
  input  logic       Incr,
  output logic [6:0] Value,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Saturated
);

  logic [6:0] value_reg;
  logic [3:0] tens_reg;
  logic [3:0] ones_reg;

  assign Saturated = (value_reg == SCORE_MAX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      value_reg <= 7'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
    end else if (Clear) begin
      value_reg <= 7'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
    end else if (Incr && !Saturated) begin
      value_reg <= value_reg + 7'd1;
      if (ones_reg == 4'd9) begin
        ones_reg <= 4'd0;
        tens_reg <= tens_reg + 4'd1;
      end else begin
        ones_reg <= ones_reg + 4'd1;
      end
    end
  end

  assign Value = value_reg;
  assign Tens  = tens_reg;
  assign Ones  = ones_reg;

endmodule

// File: rtl/score_tracker.sv
// Game score tracker: accepts line-clear reports, adds points one per cycle,
// and tracks win/lose outcome plus the best score since reset.
module score_tracker
  import tetris_pkg::*;
#(
  parameter logic [6:0] WIN_SCORE = 7'd40
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Lines_Valid,
  input  logic [2:0] Lines_Cleared,
  output logic       Lines_Ready,
  input  logic       Spawn_Blocked,
  output logic [6:0] Score,
  output logic [3:0] Score_Tens,
  output logic [3:0] Score_Ones,
  output logic [6:0] Highest,
  output logic       Playing,
  output logic       Win,
  output logic       Lose
);

  state_e     state_reg;
  logic [3:0] pending_reg;
  logic [6:0] highest_reg;

  logic       cnt_clear;
  logic       cnt_incr;
  logic       saturated;
  logic       idle_like;
  logic [6:0] score_inc;
  logic [3:0] report_pts;

  assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_WIN) || (state_reg == ST_LOSE);
  assign cnt_clear  = idle_like && Start;
  // A blocked spawn suppresses the increment of the same cycle.
  assign cnt_incr   = (state_reg == ST_ADD) && !Spawn_Blocked && !saturated;
  assign score_inc  = Score + 7'd1;
  assign report_pts = points_for(Lines_Cleared);

  bcd_counter2 u_counter (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Clear     (cnt_clear),
    .Incr      (cnt_incr),
    .Value     (Score),
    .Tens      (Score_Tens),
    .Ones      (Score_Ones),
    .Saturated (saturated)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 4'd0;
      highest_reg <= 7'd0;
    end else begin
      if (Score > highest_reg) highest_reg <= Score;
      case (state_reg)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (Start) begin
            state_reg   <= ST_PLAY;
            pending_reg <= 4'd0;
          end
        end
        ST_PLAY: begin
          if (Spawn_Blocked) begin
            state_reg <= ST_LOSE;
          end else if (Lines_Valid && (report_pts != 4'd0)) begin
            pending_reg <= report_pts;
            state_reg   <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (Spawn_Blocked) begin
            state_reg   <= ST_LOSE;
            pending_reg <= 4'd0;
          end else if (saturated) begin
            pending_reg <= 4'd0;
            state_reg   <= (Score >= WIN_SCORE) ? ST_WIN : ST_PLAY;
          end else if (score_inc >= WIN_SCORE) begin
            // Reaching the target ends the add early; leftover points are dropped.
            pending_reg <= 4'd0;
            state_reg   <= ST_WIN;
          end else begin
            pending_reg <= pending_reg - 4'd1;
            if (pending_reg == 4'd1) state_reg <= ST_PLAY;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Lines_Ready = (state_reg == ST_PLAY);
  assign Playing     = (state_reg == ST_PLAY) || (state_reg == ST_ADD);
  assign Win         = (state_reg == ST_WIN);
  assign Lose        = (state_reg == ST_LOSE);
  assign Highest     = highest_reg;

endmodule
